// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: sequences a warm reconfiguration request from the fabric
// user design to the configuration loader. It holds the user design in reset
// while the new bitstream loads and re-arms only after BOOT has been released.
// Optional feature: define WARMBOOT_TIMEOUT_EN to add a LOAD-state watchdog
// of TIMEOUT cycles.
module warmboot_ctrl #(
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned RESET_HOLD = 16,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic [3:0] SLOT,
   input  logic       BOOT,
   output logic       user_reset,
   output logic       cfg_req,
   output logic [3:0] cfg_slot,
   input  logic       cfg_ack,
   input  logic       cfg_done,
   input  logic       cfg_err,
   output logic       busy,
   output logic       boot_err,
   output logic [3:0] last_slot
);

   localparam int unsigned HOLD_W = $clog2(RESET_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);

   typedef enum logic [2:0] {
      ST_POR_HOLD,
      ST_WAIT_LOW,
      ST_IDLE,
      ST_REQ,
      ST_LOAD,
      ST_HOLD
   } state_t;

   // Reject impossible configurations at elaboration time.
   if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || RESET_HOLD < 2 || TIMEOUT < 1) begin : g_bad_params
      $error("warmboot_ctrl: parameter out of range");
   end

   state_t            state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [3:0]        cfg_slot_nxt, last_slot_nxt;
   logic              boot_err_nxt;
   logic              user_reset_nxt, cfg_req_nxt, busy_nxt;
   logic              slot_ok;

`ifdef WARMBOOT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0] wd_cnt, wd_nxt;
`endif

   assign slot_ok = ({1'b0, SLOT} < 5'(NUM_SLOTS));

   // Next-state and next-output decode; outputs are registered from state_nxt.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_nxt     = state;
      hold_nxt      = hold_cnt;
      cfg_slot_nxt  = cfg_slot;
      last_slot_nxt = last_slot;
      boot_err_nxt  = boot_err;
`ifdef WARMBOOT_TIMEOUT_EN
      wd_nxt        = wd_cnt;
`endif
      case (state)
         ST_POR_HOLD, ST_HOLD: begin
            if (hold_cnt == '0) state_nxt = ST_WAIT_LOW;
            else                hold_nxt  = hold_cnt - HOLD_W'(1);
         end
         ST_WAIT_LOW: begin
            // A BOOT level left high from the previous request must drop first.
            if (!BOOT) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (BOOT) begin
               if (slot_ok) begin
                  state_nxt     = ST_REQ;
                  cfg_slot_nxt  = SLOT;
                  last_slot_nxt = SLOT;
                  boot_err_nxt  = 1'b0;
               end else begin
                  state_nxt     = ST_WAIT_LOW;
                  boot_err_nxt  = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (cfg_ack) begin
               if (cfg_done) begin
                  // Loader accepted and finished in the same cycle.
                  state_nxt = ST_HOLD;
                  hold_nxt  = HOLD_LOAD;
                  if (cfg_err) boot_err_nxt = 1'b1;
               end else begin
                  state_nxt = ST_LOAD;
`ifdef WARMBOOT_TIMEOUT_EN
                  wd_nxt    = '0;
`endif
               end
            end
         end
         ST_LOAD: begin
            if (cfg_done) begin
               state_nxt = ST_HOLD;
               hold_nxt  = HOLD_LOAD;
               if (cfg_err) boot_err_nxt = 1'b1;
            end
`ifdef WARMBOOT_TIMEOUT_EN
            else if (wd_cnt == TO_LAST) begin
               state_nxt    = ST_HOLD;
               hold_nxt     = HOLD_LOAD;
               boot_err_nxt = 1'b1;
            end else begin
               wd_nxt = wd_cnt + TO_W'(1);
            end
`endif
         end
         default: begin
            state_nxt = ST_POR_HOLD;
            hold_nxt  = HOLD_LOAD;
         end
      endcase

      user_reset_nxt = (state_nxt == ST_POR_HOLD) || (state_nxt == ST_REQ) ||
                       (state_nxt == ST_LOAD)     || (state_nxt == ST_HOLD);
      cfg_req_nxt    = (state_nxt == ST_REQ);
      busy_nxt       = (state_nxt != ST_IDLE) && (state_nxt != ST_WAIT_LOW);
   end

   // State, counters and registered outputs; RESET wins over everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (RESET) begin
         state      <= ST_POR_HOLD;
         hold_cnt   <= HOLD_LOAD;
         user_reset <= 1'b1;
         cfg_req    <= 1'b0;
         cfg_slot   <= '0;
         busy       <= 1'b1;
         boot_err   <= 1'b0;
         last_slot  <= '0;
`ifdef WARMBOOT_TIMEOUT_EN
         wd_cnt     <= '0;
`endif
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         user_reset <= user_reset_nxt;
         cfg_req    <= cfg_req_nxt;
         cfg_slot   <= cfg_slot_nxt;
         busy       <= busy_nxt;
         boot_err   <= boot_err_nxt;
         last_slot  <= last_slot_nxt;
`ifdef WARMBOOT_TIMEOUT_EN
         wd_cnt     <= wd_nxt;
`endif
      end
   end

endmodule

// File: doc/warmboot_ctrl.md
WARMBOOT_CTRL -- requirements
Module: warmboot_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, 4: number of valid bitstream slots (1..16).
REQ-002 Parameter RESET_HOLD, 16: cycles of user_reset after power-on reset or after load completion (>=2).
REQ-003 Parameter TIMEOUT, 1024: LOAD-state watchdog limit in cycles; used only with WARMBOOT_TIMEOUT_EN.
REQ-004 Port clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port RESET  in  1  reset, synchronous, active-high.
REQ-006 Port SLOT  in  4  slot number requested by the fabric user design.
REQ-007 Port BOOT  in  1  boot request from the fabric, level-sensitive.
REQ-008 Port user_reset  out  1  reset to the fabric user design, active-high.
REQ-009 Port cfg_req  out  1  load request to the configuration loader.
REQ-010 Port cfg_slot  out  4  slot to load; valid while cfg_req=1.
REQ-011 Port cfg_ack  in  1  loader accepted the request.
REQ-012 Port cfg_done  in  1  loader finished, one-cycle pulse.
REQ-013 Port cfg_err  in  1  loader failure, qualified by cfg_done.
REQ-014 Port busy  out  1  high in every state except IDLE and WAIT_LOW.
REQ-015 Port boot_err  out  1  sticky error flag.
REQ-016 Port last_slot  out  4  slot of the most recent accepted request.

Function
REQ-017 The FSM SHALL have states POR_HOLD, WAIT_LOW, IDLE, REQ, LOAD, HOLD; all outputs registered.
REQ-018 POR_HOLD: user_reset=1 for RESET_HOLD cycles, then WAIT_LOW.
REQ-019 WAIT_LOW: user_reset=0; when BOOT=0, go to IDLE (arming); BOOT held high never re-triggers.
REQ-020 IDLE with BOOT=1 and SLOT<NUM_SLOTS: capture SLOT into cfg_slot and last_slot, clear boot_err, go REQ.
REQ-021 IDLE with BOOT=1 and SLOT>=NUM_SLOTS: set boot_err, no request, go WAIT_LOW; user_reset stays 0.
REQ-022 REQ: cfg_req=1, user_reset=1, cfg_slot stable; on cfg_ack go LOAD with cfg_req=0 the next cycle.
REQ-023 LOAD: user_reset=1; on cfg_done go HOLD; if cfg_err=1 at cfg_done, set boot_err.
REQ-024 cfg_ack and cfg_done high in the same REQ cycle SHALL be treated as completion (go HOLD directly).
REQ-025 cfg_done outside REQ/LOAD SHALL be ignored.
REQ-026 HOLD: user_reset=1 for RESET_HOLD cycles, then WAIT_LOW.
REQ-027 Latency: BOOT sampled high in IDLE -> cfg_req and user_reset high exactly 1 cycle later.
REQ-028 BOOT/SLOT changes in REQ, LOAD, HOLD SHALL be ignored.
REQ-029 Hold counter SHALL be wide enough for RESET_HOLD and reload on each entry to POR_HOLD/HOLD.

Reset
REQ-030 RESET=1 at any edge SHALL force POR_HOLD and restart the hold counter, including mid-REQ/LOAD.
REQ-031 Values after reset: user_reset=1, cfg_req=0, cfg_slot=0, busy=1, boot_err=0, last_slot=0.

Configuration
REQ-032 Macro WARMBOOT_TIMEOUT_EN defined: LOAD counts cycles; on reaching TIMEOUT without cfg_done, set boot_err and go HOLD.
REQ-033 Macro WARMBOOT_TIMEOUT_EN undefined: no watchdog logic; LOAD waits for cfg_done indefinitely; TIMEOUT unused.

Verification
REQ-034 RESET 1 cycle, BOOT=0 -> user_reset=1 for 16 cycles, then 0; busy=0; FSM in IDLE.
REQ-035 IDLE, SLOT=2, BOOT=1; cfg_ack after 3 cycles, cfg_done 5 cycles later -> cfg_req high 3 cycles with cfg_slot=2; user_reset high through LOAD plus 16; last_slot=2; boot_err=0.
REQ-036 IDLE, SLOT=5, BOOT=1 (NUM_SLOTS=4) -> no cfg_req, boot_err=1, user_reset=0; BOOT held high -> no further action until BOOT=0.
REQ-037 cfg_ack and cfg_done same cycle with cfg_err=1 -> go HOLD, boot_err=1, user_reset 16 more cycles.
REQ-038 RESET asserted during LOAD -> next cycle cfg_req=0, user_reset=1, boot_err=0, POR_HOLD 16 cycles.
REQ-039 With WARMBOOT_TIMEOUT_EN, TIMEOUT=8, no cfg_done -> boot_err=1 after 8 LOAD cycles, then HOLD; without macro -> stays in LOAD.
